uart_cmd_ctrl: RTL and testbench

- Command controller between the UART receive path and the board LEDs.
- Parses framed commands from received bytes: header 0xAA, cmd, arg, checksum, tail 0x55.
- Executes each valid command on a 4-bit active-low LED bank: set pattern, blink, or off.
- Returns a one-byte ACK or NAK to the UART transmitter through a request/busy handshake.

---
 rtl/uart_cmd_ctrl_if.sv | 20 ++
 rtl/uart_cmd_ctrl.sv | 170 +++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-level link between the UART receive/transmit path and the command controller.
// The controller takes the slave side; the UART/board environment takes the master side.
interface uart_cmd_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_flag;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_flag;
    logic [3:0] led_out;

    modport master (
        output rx_data, rx_flag, tx_busy,
        input  tx_data, tx_flag, led_out
    );

    modport slave (
        input  rx_data, rx_flag, tx_busy,
        output tx_data, tx_flag, led_out
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Frame parser (AA cmd arg sum 55) driving a 4-bit active-low LED bank and
// answering every complete frame with a one-byte ACK/NAK through a busy handshake.
module uart_cmd_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 2_500_000,
    parameter int unsigned BLINK_UNIT  = 500_000
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_cmd_ctrl_if.slave  bus
);

    localparam logic [7:0] HDR_BYTE  = 8'hAA;
    localparam logic [7:0] TAIL_BYTE = 8'h55;
    localparam logic [7:0] RESP_ACK  = 8'h06;
    localparam logic [7:0] RESP_NAK  = 8'h15;
    localparam logic [7:0] CMD_SET   = 8'h01;
    localparam logic [7:0] CMD_BLINK = 8'h02;
    localparam logic [7:0] CMD_OFF   = 8'h03;

    localparam int unsigned      TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ARG,
        SUM,
        TAIL,
        EXEC,
        ACK
    } state_t;

    state_t          state;
    logic [7:0]      cmd_q;
    logic [7:0]      arg_q;
    logic [7:0]      sum_q;
    logic [7:0]      resp_q;
    logic [TO_W-1:0] to_cnt;
    logic            blink_en;
    logic [7:0]      blink_arg;
    logic [31:0]     blink_cnt;
    logic [31:0]     blink_last;
    logic [3:0]      led_q;
    logic [7:0]      tx_data_q;
    logic            tx_flag_q;

    assign bus.led_out = led_q;
    assign bus.tx_data = tx_data_q;
    assign bus.tx_flag = tx_flag_q;

    // NOTE: all state lives in one clocked block using non-blocking assignments,
    // so later assignments in the block (command execution) cleanly override the
    // earlier default/background updates (blink toggle, tx_flag clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cmd_q      <= 8'h00;
            arg_q      <= 8'h00;
            sum_q      <= 8'h00;
            resp_q     <= 8'h00;
            to_cnt     <= '0;
            blink_en   <= 1'b0;
            blink_arg  <= 8'h00;
            blink_cnt  <= 32'd0;
            blink_last <= 32'd0;
            led_q      <= 4'b1111;
            tx_data_q  <= 8'h00;
            tx_flag_q  <= 1'b0;
        end else begin
            tx_flag_q <= 1'b0;

            if (blink_en) begin
                if (blink_cnt == blink_last) begin
                    blink_cnt <= 32'd0;
                    led_q     <= ~led_q;
                end else begin
                    blink_cnt <= blink_cnt + 32'd1;
                end
            end

            // Inter-byte watchdog: a byte in the same cycle as expiry takes priority.
            if (state inside {CMD, ARG, SUM, TAIL}) begin
                if (bus.rx_flag) begin
                    to_cnt <= '0;
                end else if (to_cnt == TO_LAST) begin
                    to_cnt <= '0;
                    state  <= IDLE;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end

            unique case (state)
                IDLE: begin
                    if (bus.rx_flag && bus.rx_data == HDR_BYTE) begin
                        to_cnt <= '0;
                        state  <= CMD;
                    end
                end
                CMD: begin
                    if (bus.rx_flag) begin
                        cmd_q <= bus.rx_data;
                        state <= ARG;
                    end
                end
                ARG: begin
                    if (bus.rx_flag) begin
                        arg_q <= bus.rx_data;
                        state <= SUM;
                    end
                end
                SUM: begin
                    if (bus.rx_flag) begin
                        sum_q <= bus.rx_data;
                        state <= TAIL;
                    end
                end
                TAIL: begin
                    if (bus.rx_flag) begin
                        if (bus.rx_data == TAIL_BYTE && sum_q == (cmd_q ^ arg_q)) begin
                            state <= EXEC;
                        end else begin
                            resp_q <= RESP_NAK;
                            state  <= ACK;
                        end
                    end
                end
                EXEC: begin
                    state  <= ACK;
                    resp_q <= RESP_ACK;
                    unique case (cmd_q)
                        CMD_SET: begin
                            led_q    <= arg_q[3:0];
                            blink_en <= 1'b0;
                        end
                        CMD_BLINK: begin
                            if (arg_q == 8'h00) begin
                                blink_en <= 1'b0;
                                led_q    <= led_q;
                            end else begin
                                blink_en   <= 1'b1;
                                blink_arg  <= arg_q;
                                blink_last <= ({24'd0, arg_q} * BLINK_UNIT) - 32'd1;
                                // A re-issue with the same period keeps the current phase.
                                if (!blink_en || arg_q != blink_arg) begin
                                    blink_cnt <= 32'd0;
                                    led_q     <= led_q;
                                end
                            end
                        end
                        CMD_OFF: begin
                            led_q    <= 4'b1111;
                            blink_en <= 1'b0;
                        end
                        default: resp_q <= RESP_NAK;
                    endcase
                end
                ACK: begin
                    if (!bus.tx_busy) begin
                        tx_flag_q <= 1'b1;
                        tx_data_q <= resp_q;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with short timeout/blink parameters so
// every frame, blink period and watchdog expiry fits in a few hundred cycles.
module tb_uart_cmd_ctrl;

    localparam int unsigned TIMEOUT_CYC = 16;
    localparam int unsigned BLINK_UNIT  = 4;

    logic clk;
    logic rst_n;

    uart_cmd_ctrl_if bus ();

    uart_cmd_ctrl #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .BLINK_UNIT  (BLINK_UNIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec    = 0;
    int n_miss   = 0;
    int tx_count = 0;
    int snap;
    int hi;

    logic [7:0] junk [5] = '{8'hAA, 8'h01, 8'h00, 8'h01, 8'h55};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pre-edge value of tx_flag: counts request pulses without racing the negedge checks.
    always @(posedge clk) if (bus.tx_flag) tx_count = tx_count + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_flag = 1'b1;
        @(negedge clk);
        bus.rx_flag = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                              input logic [7:0] s, input logic [7:0] t);
        send_byte(8'hAA);
        send_byte(c);
        send_byte(a);
        send_byte(s);
        send_byte(t);
    endtask

    task automatic wait_tx(input string tag, input logic [7:0] exp, input int budget);
        int n = 0;
        while (!bus.tx_flag && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_flag"}, 32'(bus.tx_flag), 32'd1);
        check({tag, "_data"}, 32'(bus.tx_data), 32'(exp));
        @(negedge clk);
        check({tag, "_width"}, 32'(bus.tx_flag), 32'd0);
        check({tag, "_hold"}, 32'(bus.tx_data), 32'(exp));
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.rx_data = 8'h00;
        bus.rx_flag = 1'b0;
        bus.tx_busy = 1'b0;
        idle(3);
        check("rst_led", 32'(bus.led_out), 32'hF);
        check("rst_txf", 32'(bus.tx_flag), 32'd0);
        check("rst_txd", 32'(bus.tx_data), 32'h00);
        rst_n = 1'b1;
        idle(2);

        // Set pattern, then a bad checksum that must leave the LEDs alone.
        snap = tx_count;
        send_frame(8'h01, 8'h05, 8'h04, 8'h55);
        @(negedge clk);
        check("set_led", 32'(bus.led_out), 32'h5);
        check("set_txf_early", 32'(bus.tx_flag), 32'd0);
        wait_tx("set_ack", 8'h06, 8);
        send_frame(8'h01, 8'h05, 8'h00, 8'h55);
        wait_tx("badsum_nak", 8'h15, 8);
        check("badsum_led", 32'(bus.led_out), 32'h5);
        idle(2);
        check("pulses_12", 32'(tx_count - snap), 32'd2);

        // Transmitter busy: hold the response, drop bytes arriving meanwhile.
        snap = tx_count;
        bus.tx_busy = 1'b1;
        send_frame(8'h01, 8'h0F, 8'h0E, 8'h55);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (i < 5) begin
                bus.rx_data = junk[i];
                bus.rx_flag = 1'b1;
            end else begin
                bus.rx_flag = 1'b0;
            end
            @(negedge clk);
            if (bus.tx_flag) hi++;
        end
        bus.rx_flag = 1'b0;
        check("busy_hold", 32'(hi), 32'd0);
        bus.tx_busy = 1'b0;
        wait_tx("busy_ack", 8'h06, 4);
        check("busy_led", 32'(bus.led_out), 32'hF);
        idle(10);
        check("busy_dropped_pulses", 32'(tx_count - snap), 32'd1);
        check("busy_dropped_led", 32'(bus.led_out), 32'hF);

        // Blink with half-period 2*4 = 8 cycles, then switch off.
        send_frame(8'h01, 8'h05, 8'h04, 8'h55);
        wait_tx("set2_ack", 8'h06, 8);
        send_frame(8'h02, 8'h02, 8'h00, 8'h55);
        @(negedge clk);
        check("blink_start", 32'(bus.led_out), 32'h5);
        wait_tx("blink_ack", 8'h06, 8);
        idle(5);
        check("blink_pre", 32'(bus.led_out), 32'h5);
        idle(1);
        check("blink_t1", 32'(bus.led_out), 32'hA);
        idle(7);
        check("blink_pre2", 32'(bus.led_out), 32'hA);
        idle(1);
        check("blink_t2", 32'(bus.led_out), 32'h5);
        send_frame(8'h03, 8'h03, 8'h00, 8'h55);
        @(negedge clk);
        check("off_led", 32'(bus.led_out), 32'hF);
        wait_tx("off_ack", 8'h06, 8);
        idle(20);
        check("off_stopped", 32'(bus.led_out), 32'hF);

        // Silence after AA 01: silent return to IDLE, then a clean frame.
        snap = tx_count;
        send_byte(8'hAA);
        send_byte(8'h01);
        idle(40);
        check("to_no_tx", 32'(tx_count - snap), 32'd0);
        check("to_led", 32'(bus.led_out), 32'hF);
        send_frame(8'h01, 8'h03, 8'h02, 8'h55);
        wait_tx("to_after_ack", 8'h06, 8);
        check("to_after_led", 32'(bus.led_out), 32'h3);

        // 15 idle cycles after the header: next byte lands on the expiry cycle and wins.
        send_byte(8'hAA);
        idle(15);
        send_byte(8'h01);
        send_byte(8'h06);
        send_byte(8'h07);
        send_byte(8'h55);
        wait_tx("to_edge_ack", 8'h06, 8);
        check("to_edge_led", 32'(bus.led_out), 32'h6);

        // Garbage before a frame, then an unknown command.
        snap = tx_count;
        send_byte(8'h12);
        send_byte(8'h34);
        send_frame(8'h7F, 8'h00, 8'h7F, 8'h55);
        wait_tx("unk_nak", 8'h15, 8);
        check("unk_led", 32'(bus.led_out), 32'h6);

        // Reset while in ARG.
        send_byte(8'hAA);
        send_byte(8'h01);
        rst_n = 1'b0;
        #1;
        check("mid_rst_led", 32'(bus.led_out), 32'hF);
        check("mid_rst_txf", 32'(bus.tx_flag), 32'd0);
        check("mid_rst_txd", 32'(bus.tx_data), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        idle(10);
        check("mid_rst_pulses", 32'(tx_count - snap), 32'd1);
        check("mid_rst_led_hold", 32'(bus.led_out), 32'hF);
        send_frame(8'h01, 8'h0A, 8'h0B, 8'h55);
        wait_tx("post_rst_ack", 8'h06, 8);
        check("post_rst_led", 32'(bus.led_out), 32'hA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
